sync_fifo_param: RTL and testbench

//  Next-generation single-clock FIFO: generalised width/depth, programmable

---
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, almost-full/empty levels,
// and a choice of registered or first-word-fall-through read data.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   data_in       write data, accepted on wr_en when not full
//   wr_en, rd_en  write / read requests
//   data_out      read data (registered on read, or live head in FWFT)
//   wr_ack        one cycle after an accepted write
//   overflow      one cycle after a write rejected because full
//   underflow     one cycle after a read rejected because empty
//   full, empty   occupancy is FIFO_DEPTH / zero
//   almostfull    count >= AF_LEVEL
//   almostempty   count <= AE_LEVEL
//   count         occupancy, 0..FIFO_DEPTH
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL ||
      AF_LEVEL > FIFO_DEPTH) begin : g_param_err
    $error("sync_fifo_param: illegal parameters");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic [FIFO_WIDTH-1:0] head;

  logic wr_ok;
  logic rd_ok;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C);
  assign almostempty = (count_q <= AE_C);

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Fall-through head reads as zero while nothing is stored.
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = wr_ok;
    ovf_d    = wr_en & full;
    unf_d    = rd_en & empty;
    // Power-of-two depth: pointer wrap is natural overflow.
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (!FWFT && rd_ok) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = FWFT ? head : dout_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a registered-read FIFO (AF=6, AE=2) driven from a
// vector table, and a fall-through FIFO exercised by hand sequences.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: FWFT=0, AF=6, AE=2
  logic        rst0, wr0, rd0;
  logic [15:0] din0, dout0;
  logic        ack0, ovf0, unf0, full0, emp0, af0, ae0;
  logic [3:0]  cnt0;

  // DUT1: FWFT=1, default levels (AF=7, AE=1)
  logic        rst1, wr1, rd1;
  logic [15:0] din1, dout1;
  logic        ack1, ovf1, unf1, full1, emp1, af1, ae1;
  logic [3:0]  cnt1;

  sync_fifo_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8),
    .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst0), .data_in(din0),
    .wr_en(wr0), .rd_en(rd0), .data_out(dout0),
    .wr_ack(ack0), .overflow(ovf0), .underflow(unf0),
    .full(full0), .empty(emp0), .almostfull(af0),
    .almostempty(ae0), .count(cnt0)
  );

  sync_fifo_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .data_in(din1),
    .wr_en(wr1), .rd_en(rd1), .data_out(dout1),
    .wr_ack(ack1), .overflow(ovf1), .underflow(unf1),
    .full(full1), .empty(emp1), .almostfull(af1),
    .almostempty(ae1), .count(cnt1)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [26:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {count, wr_ack, overflow, underflow, full, empty, af, ae, data_out}
  function automatic logic [26:0] mk(
    int c, bit ack, bit ovf, bit unf, bit fu,
    bit em, bit af, bit ae, logic [15:0] d);
    mk = {4'(c), ack, ovf, unf, fu, em, af, ae, d};
  endfunction

  function automatic logic [26:0] obs0();
    obs0 = {cnt0, ack0, ovf0, unf0, full0, emp0, af0, ae0, dout0};
  endfunction

  function automatic logic [26:0] obs1();
    obs1 = {cnt1, ack1, ovf1, unf1, full1, emp1, af1, ae1, dout1};
  endfunction

  function automatic void add(string n, bit w, bit r,
    logic [15:0] d, logic [26:0] e);
    vec_t v;
    v.name = n; v.wr = w; v.rd = r; v.din = d; v.exp = e;
    vq.push_back(v);
  endfunction

  task automatic chk(string n, logic [26:0] act,
    logic [26:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d flags=%b dout=%h, want cnt=%0d flags=%b dout=%h",
        n, act[26:23], act[22:16], act[15:0],
        exp[26:23], exp[22:16], exp[15:0]);
    end
  endtask

  task automatic step1(bit r, bit w, bit rd,
    logic [15:0] d);
    @(negedge clk);
    rst1 = r; wr1 = w; rd1 = rd; din1 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; wr0 = 0; rd0 = 0; din0 = '0;
    rst1 = 1'b1; wr1 = 0; rd1 = 0; din1 = '0;

    // Fill 1..8: ae drops at 3, af rises at 6.
    for (int k = 1; k <= 8; k++)
      add($sformatf("wr%0d", k), 1, 0, 16'(k),
        mk(k, 1, 0, 0, k == 8, 0, k >= 6, k <= 2, 16'h0));
    add("wr_overflow", 1, 0, 16'h0009,
      mk(8, 0, 1, 0, 1, 0, 1, 0, 16'h0));
    for (int k = 1; k <= 8; k++)
      add($sformatf("rd%0d", k), 0, 1, 16'h0,
        mk(8 - k, 0, 0, 0, 0, k == 8, (8 - k) >= 6,
           (8 - k) <= 2, 16'(k)));
    add("rd_underflow", 0, 1, 16'h0,
      mk(0, 0, 0, 1, 0, 1, 0, 1, 16'h0008));
    // Prime to 4, then 20 cycles of simultaneous traffic.
    for (int k = 1; k <= 4; k++)
      add($sformatf("pre%0d", k), 1, 0, 16'(16'h10 + k),
        mk(k, 1, 0, 0, 0, 0, 0, k <= 2, 16'h0008));
    for (int i = 1; i <= 20; i++)
      add($sformatf("both%0d", i), 1, 1, 16'(16'h14 + i),
        mk(4, 1, 0, 0, 0, 0, 0, 0, 16'(16'h10 + i)));
    // Top up to full; FIFO now holds 0x25..0x2C.
    for (int k = 5; k <= 8; k++)
      add($sformatf("top%0d", k), 1, 0, 16'(16'h24 + k),
        mk(k, 1, 0, 0, k == 8, 0, k >= 6, 0, 16'h0024));
    add("both_full", 1, 1, 16'h002D,
      mk(7, 0, 1, 0, 0, 0, 1, 0, 16'h0025));
    for (int k = 1; k <= 7; k++)
      add($sformatf("drain%0d", k), 0, 1, 16'h0,
        mk(7 - k, 0, 0, 0, 0, k == 7, (7 - k) >= 6,
           (7 - k) <= 2, 16'(16'h25 + k)));
    add("both_empty", 1, 1, 16'h0030,
      mk(1, 1, 0, 1, 0, 0, 0, 1, 16'h002C));
    add("rd_last", 0, 1, 16'h0,
      mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0030));

    // DUT0 reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("reset0", obs0(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));

    foreach (vq[i]) begin
      @(negedge clk);
      wr0 = vq[i].wr; rd0 = vq[i].rd; din0 = vq[i].din;
      @(posedge clk);
      #1;
      chk(vq[i].name, obs0(), vq[i].exp);
    end

    // Reset while holding data
    @(negedge clk);
    wr0 = 1; rd0 = 0; din0 = 16'h0077;
    @(posedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid0", obs0(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));
    @(negedge clk);
    rst0 = 1'b0; wr0 = 0;

    // DUT1: fall-through mode
    step1(1, 0, 0, 16'h0);
    step1(1, 0, 0, 16'h0);
    step1(0, 0, 0, 16'h0);
    chk("reset1", obs1(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));
    step1(0, 1, 0, 16'hA5A5);
    chk("fwft_head", obs1(), mk(1, 1, 0, 0, 0, 0, 0, 1, 16'hA5A5));
    step1(0, 0, 1, 16'h0);
    chk("fwft_pop", obs1(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));
    step1(0, 1, 0, 16'h00B1);
    chk("fwft_b1", obs1(), mk(1, 1, 0, 0, 0, 0, 0, 1, 16'h00B1));
    step1(0, 1, 0, 16'h00B2);
    chk("fwft_b2", obs1(), mk(2, 1, 0, 0, 0, 0, 0, 0, 16'h00B1));
    step1(0, 0, 1, 16'h0);
    chk("fwft_next", obs1(), mk(1, 0, 0, 0, 0, 0, 0, 1, 16'h00B2));
    step1(0, 0, 1, 16'h0);
    chk("fwft_empty", obs1(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));
    step1(0, 0, 1, 16'h0);
    chk("fwft_unf", obs1(), mk(0, 0, 0, 1, 0, 1, 0, 1, 16'h0));
    for (int k = 1; k <= 5; k++) begin
      step1(0, 1, 0, 16'(16'hC0 + k));
      chk($sformatf("fwft_fill%0d", k), obs1(),
        mk(k, 1, 0, 0, 0, 0, 0, k <= 1, 16'h00C1));
    end
    step1(1, 1, 1, 16'h00DD);
    chk("rst_mid1", obs1(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));
    step1(0, 0, 0, 16'h0);
    chk("post_rst1", obs1(), mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
